// File: rtl/apb_spi_ncs_pkg.sv
// Shared definitions for the APB SPI master: register offsets, CTRL field
// positions, controller state encoding and the bit-order helper.
package apb_spi_ncs_pkg;

   localparam logic [7:0] REG_CTRL   = 8'h00;
   localparam logic [7:0] REG_CLKDIV = 8'h04;
   localparam logic [7:0] REG_LEN    = 8'h08;
   localparam logic [7:0] REG_STATUS = 8'h0C;
   localparam logic [7:0] REG_TXDATA = 8'h10;
   localparam logic [7:0] REG_RXDATA = 8'h14;
   localparam logic [7:0] REG_INT    = 8'h18;

   localparam int CTRL_START = 0;
   localparam int CTRL_CPOL  = 1;
   localparam int CTRL_CPHA  = 2;
   localparam int CTRL_LSB   = 3;
   localparam int CTRL_SWRST = 4;
   localparam int CTRL_CS_LO = 8;
   localparam int CTRL_CS_HI = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_LOAD,
      ST_SHIFT,
      ST_STORE,
      ST_CS_HOLD
   } spi_state_e;

   // Physical bit position of the idx-th bit on the wire.
   function automatic logic [5:0] bit_pos(input logic lsb, input logic [5:0] last,
                                          input logic [5:0] idx);
      return lsb ? idx : last - idx;
   endfunction

endpackage

// File: rtl/spi_ncs_fifo.sv
// First-word-fall-through FIFO with exact occupancy count and synchronous clear.
module spi_ncs_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      push,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic                      pop,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wptr, rptr;
   logic                  do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/apb_spi_master_ncs.sv
// APB-programmable SPI master with TX/RX FIFOs, selectable mode, bit order,
// frame length and chip select.
module apb_spi_master_ncs
   import apb_spi_ncs_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int NUM_CS         = 4,
   parameter int APB_ADDR_WIDTH = 12
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic                      events_o,
   output logic                      spi_clk,
   output logic [NUM_CS-1:0]         spi_csn,
   output logic                      spi_sdo,
   output logic                      spi_oe,
   input  logic                      spi_sdi
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic        cpol, cpha, lsb_first, en_tx, en_rx;
   logic [2:0]  cs_idx;
   logic [15:0] div, frame_cnt, rem_cnt, hp_cnt;
   logic [5:0]  flen, bit_idx;
   logic [6:0]  tx_th, rx_th, edge_cnt, tx_elems, rx_elems;
   logic [63:0] tx_sr, rx_sr, tx_word;
   logic        sck_q, sdo_q, busy, tick, last_edge, counting;
   spi_state_e  state, state_n;

   logic [31:0]   tx_rdata, rx_rdata;
   logic          tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
   logic [CW-1:0] tx_cnt, rx_cnt;

   logic acc, wr, rd, sel_ctrl, sel_div, sel_len, sel_stat, sel_tx, sel_rx, sel_int;
   logic swrst, cs_bad, ctrl_ok, start_go, cfg_wr;

   assign acc      = PSEL && PENABLE;
   assign wr       = acc && PWRITE;
   assign rd       = acc && !PWRITE;
   assign sel_ctrl = (PADDR == APB_ADDR_WIDTH'(REG_CTRL));
   assign sel_div  = (PADDR == APB_ADDR_WIDTH'(REG_CLKDIV));
   assign sel_len  = (PADDR == APB_ADDR_WIDTH'(REG_LEN));
   assign sel_stat = (PADDR == APB_ADDR_WIDTH'(REG_STATUS));
   assign sel_tx   = (PADDR == APB_ADDR_WIDTH'(REG_TXDATA));
   assign sel_rx   = (PADDR == APB_ADDR_WIDTH'(REG_RXDATA));
   assign sel_int  = (PADDR == APB_ADDR_WIDTH'(REG_INT));

   assign busy     = (state != ST_IDLE);
   // Soft reset is honoured even mid-transfer; other CTRL fields are not.
   assign swrst    = wr && sel_ctrl && PWDATA[CTRL_SWRST];
   assign cs_bad   = int'(PWDATA[CTRL_CS_HI:CTRL_CS_LO]) >= NUM_CS;
   assign ctrl_ok  = wr && sel_ctrl && !swrst && !busy && !cs_bad;
   assign start_go = ctrl_ok && PWDATA[CTRL_START] && (frame_cnt != 16'd0);
   assign cfg_wr   = wr && !busy;

   assign tx_push  = wr && sel_tx;
   assign tx_pop   = (state == ST_LOAD) && !tx_empty && !swrst;
   assign rx_push  = (state == ST_STORE) && !rx_full && !swrst;
   assign rx_pop   = rd && sel_rx && !rx_empty;
   assign tx_elems = 7'(tx_cnt);
   assign rx_elems = 7'(rx_cnt);
   assign tx_word  = {32'd0, tx_rdata};

   spi_ncs_fifo #(.DATA_WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(HCLK), .rst(HRESET), .clr(swrst), .push(tx_push), .wdata(PWDATA),
      .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
   );

   spi_ncs_fifo #(.DATA_WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(HCLK), .rst(HRESET), .clr(swrst), .push(rx_push), .wdata(rx_sr[31:0]),
      .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
   );

   always_comb begin
      PRDATA = 32'd0;
      if (rd && !HRESET) begin
         if (sel_ctrl) PRDATA = {21'd0, cs_idx, 4'd0, lsb_first, cpha, cpol, 1'b0};
         if (sel_div)  PRDATA = {16'd0, div};
         if (sel_len)  PRDATA = {frame_cnt, 10'd0, flen};
         if (sel_stat) PRDATA = {9'd0, rx_elems, 1'b0, tx_elems, 7'd0, busy};
         if (sel_rx && !rx_empty) PRDATA = rx_rdata;
         if (sel_int)  PRDATA = {14'd0, en_rx, en_tx, 1'b0, rx_th, 1'b0, tx_th};
      end
   end

   assign PREADY   = 1'b1;
   assign PSLVERR  = acc && !HRESET &&
                     (!(sel_ctrl || sel_div || sel_len || sel_stat || sel_tx || sel_rx || sel_int)
                      || (wr && sel_ctrl && !swrst && (busy || cs_bad))
                      || (wr && (sel_div || sel_len) && busy)
                      || (wr && sel_tx && tx_full && !tx_pop)
                      || (rd && sel_rx && rx_empty));
   assign events_o = (en_tx && (tx_elems < tx_th)) || (en_rx && (rx_elems > rx_th));

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         {cpol, cpha, lsb_first, cs_idx} <= '0;
         div       <= '0;
         flen      <= '0;
         frame_cnt <= '0;
         {en_rx, en_tx, rx_th, tx_th} <= '0;
      end else begin
         if (ctrl_ok) begin
            cpol      <= PWDATA[CTRL_CPOL];
            cpha      <= PWDATA[CTRL_CPHA];
            lsb_first <= PWDATA[CTRL_LSB];
            cs_idx    <= PWDATA[CTRL_CS_HI:CTRL_CS_LO];
         end
         if (cfg_wr && sel_div) div <= PWDATA[15:0];
         if (cfg_wr && sel_len) begin
            flen      <= PWDATA[5:0];
            frame_cnt <= PWDATA[31:16];
         end
         if (wr && sel_int) {en_rx, en_tx, rx_th, tx_th} <= {PWDATA[17:16], PWDATA[14:8], PWDATA[6:0]};
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) state <= ST_IDLE;
      else        state <= state_n;
   end

   assign counting  = (state == ST_CS_SETUP) || (state == ST_SHIFT) || (state == ST_CS_HOLD);
   assign tick      = (hp_cnt == div);
   assign bit_idx   = edge_cnt[6:1];
   assign last_edge = (edge_cnt == {flen, 1'b1});

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:     if (start_go) state_n = ST_CS_SETUP;
         ST_CS_SETUP: if (tick) state_n = ST_LOAD;
         ST_LOAD:     if (!tx_empty) state_n = ST_SHIFT;
         ST_SHIFT:    if (tick && last_edge) state_n = ST_STORE;
         ST_STORE:    if (!rx_full) state_n = (rem_cnt == 16'd1) ? ST_CS_HOLD : ST_LOAD;
         ST_CS_HOLD:  if (tick) state_n = ST_IDLE;
         default:     state_n = ST_IDLE;
      endcase
      if (swrst) state_n = ST_IDLE;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         hp_cnt   <= '0;
         edge_cnt <= '0;
         rem_cnt  <= '0;
         sck_q    <= 1'b0;
         sdo_q    <= 1'b0;
         tx_sr    <= '0;
         rx_sr    <= '0;
      end else if (swrst) begin
         hp_cnt   <= '0;
         edge_cnt <= '0;
         sck_q    <= cpol;
         sdo_q    <= 1'b0;
      end else begin
         hp_cnt <= (counting && !tick) ? hp_cnt + 16'd1 : 16'd0;
         if (state != ST_SHIFT) begin
            sck_q    <= cpol;
            edge_cnt <= '0;
         end
         case (state)
            ST_IDLE: if (start_go) rem_cnt <= frame_cnt;
            ST_LOAD: if (!tx_empty) begin
               tx_sr <= tx_word;
               rx_sr <= '0;
               sdo_q <= tx_word[bit_pos(lsb_first, flen, 6'd0)];
            end
            // Even edge_cnt is an odd SCK edge: sample when it matches CPHA, else drive.
            ST_SHIFT: if (tick) begin
               sck_q    <= ~sck_q;
               edge_cnt <= edge_cnt + 7'd1;
               if (edge_cnt[0] == cpha) rx_sr[bit_pos(lsb_first, flen, bit_idx)] <= spi_sdi;
               else if (cpha) sdo_q <= tx_sr[bit_pos(lsb_first, flen, bit_idx)];
               else if (bit_idx != flen) sdo_q <= tx_sr[bit_pos(lsb_first, flen, bit_idx + 6'd1)];
            end
            ST_STORE: if (!rx_full) rem_cnt <= rem_cnt - 16'd1;
            default: ;
         endcase
      end
   end

   assign spi_clk = (state == ST_SHIFT) ? sck_q : cpol;
   assign spi_sdo = sdo_q;
   assign spi_oe  = busy;

   always_comb begin
      for (int i = 0; i < NUM_CS; i++) spi_csn[i] = !(busy && (cs_idx == 3'(i)));
   end

endmodule

// File: tb/tb_apb_spi_master_ncs.sv
// Directed bench for apb_spi_master_ncs with MOSI looped back to MISO.
module tb_apb_spi_master_ncs;
   localparam logic [11:0] A_CTRL = 12'h000, A_DIV = 12'h004, A_LEN = 12'h008, A_STAT = 12'h00C;
   localparam logic [11:0] A_TX = 12'h010, A_RX = 12'h014, A_INT = 12'h018;

   logic        HCLK = 1'b0, HRESET = 1'b1;
   logic [11:0] PADDR = '0;
   logic [31:0] PWDATA = '0, PRDATA;
   logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
   logic        PREADY, PSLVERR, events_o, spi_clk, spi_sdo, spi_oe, spi_sdi;
   logic [3:0]  spi_csn;

   int n_cmp = 0, n_fail = 0;
   int mon_edges = 0;
   int csn_low [4] = '{0, 0, 0, 0};
   int sdo_cnt = 0;
   logic [63:0] sdo_hist = '0;
   logic sck_prev = 1'b0;

   assign spi_sdi = spi_sdo;
   always #5 HCLK = ~HCLK;

   apb_spi_master_ncs dut (
      .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .events_o(events_o), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_sdo(spi_sdo),
      .spi_oe(spi_oe), .spi_sdi(spi_sdi)
   );

   // Line monitor: SCK edge count, MOSI captured on rising SCK, CS low time.
   always @(negedge HCLK) begin
      if (spi_clk !== sck_prev) begin
         mon_edges <= mon_edges + 1;
         if (spi_clk === 1'b1) begin
            sdo_hist <= {sdo_hist[62:0], spi_sdo};
            sdo_cnt  <= sdo_cnt + 1;
         end
      end
      sck_prev <= spi_clk;
      for (int i = 0; i < 4; i++) if (spi_csn[i] === 1'b0) csn_low[i] <= csn_low[i] + 1;
   end

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
      @(posedge HCLK); #1;
      PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge HCLK); #1 PENABLE = 1'b1;
      #1 err = PSLVERR;
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
      @(posedge HCLK); #1;
      PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge HCLK); #1 PENABLE = 1'b1;
      #1 begin d = PRDATA; err = PSLVERR; end
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (spi_oe !== 1'b0 && k < 5000) begin @(negedge HCLK); k++; end
      #1;
      n_cmp++;
      if (spi_oe !== 1'b0) begin n_fail++; $display("FAIL %s: busy still %b after %0d cycles, required 0", nm, spi_oe, k); end
   endtask

   task automatic wait_edges(input int base, input int n, input string nm);
      int k = 0;
      while ((mon_edges - base) < n && k < 5000) begin @(negedge HCLK); k++; end
      #1;
      n_cmp++;
      if ((mon_edges - base) < n) begin n_fail++; $display("FAIL %s: saw %0d SCK edges, required %0d", nm, mon_edges - base, n); end
   endtask

   task automatic test_reset;
      logic [31:0] d; logic e;
      repeat (3) @(posedge HCLK);
      #1;
      n_cmp++; if (spi_csn !== 4'hF) begin n_fail++; $display("FAIL rst_csn: got %h required f", spi_csn); end
      n_cmp++; if ({spi_clk, spi_sdo, spi_oe, events_o} !== 4'b0) begin n_fail++; $display("FAIL rst_pins: clk/sdo/oe/ev got %b required 0000", {spi_clk, spi_sdo, spi_oe, events_o}); end
      n_cmp++; if (PRDATA !== 32'd0 || PSLVERR !== 1'b0 || PREADY !== 1'b1) begin n_fail++; $display("FAIL rst_apb: prdata %h slverr %b pready %b required 0 0 1", PRDATA, PSLVERR, PREADY); end
      HRESET = 1'b0;
      apb_read(A_STAT, d, e);
      n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_status: got %h required 0", d); end
      apb_read(A_LEN, d, e);
      n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_len: got %h required 0", d); end
   endtask

   task automatic test_mode0;
      logic [31:0] d; logic e; int eb; int cl [4];
      apb_write(A_DIV, 32'd0, e);
      apb_write(A_LEN, 32'h0001_0007, e);
      apb_write(A_TX, 32'h0000_00A5, e);
      eb = mon_edges; cl = csn_low;
      apb_write(A_CTRL, 32'h0000_0001, e);
      n_cmp++; if (spi_oe !== 1'b1) begin n_fail++; $display("FAIL m0_busy: got %b required 1", spi_oe); end
      wait_idle("m0_done");
      n_cmp++; if (mon_edges - eb !== 16) begin n_fail++; $display("FAIL m0_edges: got %0d required 16", mon_edges - eb); end
      n_cmp++; if (csn_low[0] == cl[0] || csn_low[1] != cl[1] || csn_low[2] != cl[2] || csn_low[3] != cl[3])
         begin n_fail++; $display("FAIL m0_csn: only csn0 required low, low counts %0d %0d %0d %0d", csn_low[0]-cl[0], csn_low[1]-cl[1], csn_low[2]-cl[2], csn_low[3]-cl[3]); end
      apb_read(A_RX, d, e);
      n_cmp++; if (d !== 32'h0000_00A5 || e !== 1'b0) begin n_fail++; $display("FAIL m0_rx: got %h err %b required 000000a5 err 0", d, e); end
      apb_read(A_STAT, d, e);
      n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL m0_status: got %h required 0", d); end
   endtask

   task automatic test_cpol_cpha_lsb;
      logic [31:0] d; logic e; int eb, sb; int cl [4];
      apb_write(A_LEN, 32'h0001_000B, e);
      apb_write(A_TX, 32'h0000_0123, e);
      apb_write(A_CTRL, 32'h0000_020E, e);
      n_cmp++; if (spi_clk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_pre: sck %b required 1", spi_clk); end
      repeat (2) @(posedge HCLK);
      eb = mon_edges; sb = sdo_cnt; cl = csn_low;
      apb_write(A_CTRL, 32'h0000_020F, e);
      wait_idle("m3_done");
      n_cmp++; if (mon_edges - eb !== 24) begin n_fail++; $display("FAIL m3_edges: got %0d required 24", mon_edges - eb); end
      n_cmp++; if (sdo_cnt - sb !== 12 || sdo_hist[11:0] !== 12'hC48) begin n_fail++; $display("FAIL m3_sdo: %0d bits %h required 12 bits c48", sdo_cnt - sb, sdo_hist[11:0]); end
      n_cmp++; if (csn_low[2] == cl[2] || csn_low[0] != cl[0] || csn_low[1] != cl[1] || csn_low[3] != cl[3])
         begin n_fail++; $display("FAIL m3_csn: only csn2 required low, low counts %0d %0d %0d %0d", csn_low[0]-cl[0], csn_low[1]-cl[1], csn_low[2]-cl[2], csn_low[3]-cl[3]); end
      n_cmp++; if (spi_clk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_post: sck %b required 1", spi_clk); end
      apb_read(A_RX, d, e);
      n_cmp++; if (d !== 32'h0000_0123) begin n_fail++; $display("FAIL m3_rx: got %h required 00000123", d); end
      apb_write(A_CTRL, 32'h0000_0000, e);
   endtask

   task automatic test_stall;
      logic [31:0] d; logic e; int eb;
      apb_write(A_LEN, 32'h0003_0007, e);
      apb_write(A_TX, 32'h0000_0011, e);
      eb = mon_edges;
      apb_write(A_CTRL, 32'h0000_0001, e);
      wait_edges(eb, 16, "stall_first");
      repeat (12) @(negedge HCLK);
      #1;
      n_cmp++; if (spi_oe !== 1'b1 || spi_csn[0] !== 1'b0) begin n_fail++; $display("FAIL stall_hold: oe %b csn0 %b required 1 0", spi_oe, spi_csn[0]); end
      n_cmp++; if (mon_edges - eb !== 16 || spi_clk !== 1'b0) begin n_fail++; $display("FAIL stall_sck: edges %0d sck %b required 16 0", mon_edges - eb, spi_clk); end
      apb_write(A_TX, 32'h0000_0022, e);
      apb_write(A_TX, 32'h0000_0033, e);
      wait_idle("stall_done");
      n_cmp++; if (mon_edges - eb !== 48) begin n_fail++; $display("FAIL stall_edges: got %0d required 48", mon_edges - eb); end
      apb_read(A_STAT, d, e);
      n_cmp++; if (d !== 32'h0003_0000) begin n_fail++; $display("FAIL stall_status: got %h required 00030000", d); end
      apb_read(A_RX, d, e);
      n_cmp++; if (d !== 32'h11) begin n_fail++; $display("FAIL stall_rx0: got %h required 11", d); end
      apb_read(A_RX, d, e);
      n_cmp++; if (d !== 32'h22) begin n_fail++; $display("FAIL stall_rx1: got %h required 22", d); end
      apb_read(A_RX, d, e);
      n_cmp++; if (d !== 32'h33) begin n_fail++; $display("FAIL stall_rx2: got %h required 33", d); end
   endtask

   task automatic test_fifo_limits;
      logic [31:0] d; logic e, any_err;
      any_err = 1'b0;
      for (int i = 0; i < 8; i++) begin
         apb_write(A_TX, 32'h100 + i, e);
         any_err = any_err | e;
      end
      n_cmp++; if (any_err !== 1'b0) begin n_fail++; $display("FAIL fill_err: got %b required 0", any_err); end
      apb_write(A_TX, 32'hBAD, e);
      n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b required 1", e); end
      apb_read(A_STAT, d, e);
      n_cmp++; if (d[14:8] !== 7'd8) begin n_fail++; $display("FAIL tx_elems_full: got %0d required 8", d[14:8]); end
      apb_read(A_RX, d, e);
      n_cmp++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL rx_empty_read: err %b data %h required 1 0", e, d); end
      apb_read(A_DIV + 12'h100, d, e);
      n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL unmapped_err: got %b required 1", e); end
      apb_write(A_CTRL, 32'h0000_0010, e);
      apb_read(A_STAT, d, e);
      n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL swrst_clear_tx: status %h required 0", d); end
   endtask

   task automatic test_events;
      logic [31:0] d; logic e; int eb, k;
      apb_write(A_INT, 32'h0002_0100, e);
      apb_write(A_LEN, 32'h0002_0007, e);
      apb_write(A_TX, 32'h01, e);
      apb_write(A_TX, 32'h02, e);
      n_cmp++; if (events_o !== 1'b0) begin n_fail++; $display("FAIL ev_pre: got %b required 0", events_o); end
      eb = mon_edges;
      apb_write(A_CTRL, 32'h0000_0001, e);
      k = 0;
      while (events_o !== 1'b1 && k < 2000) begin @(negedge HCLK); k++; end
      #1;
      n_cmp++; if (events_o !== 1'b1 || mon_edges - eb !== 32) begin n_fail++; $display("FAIL ev_rise: ev %b at edge %0d required 1 at 32", events_o, mon_edges - eb); end
      wait_idle("ev_done");
      apb_read(A_RX, d, e);
      n_cmp++; if (d !== 32'h01) begin n_fail++; $display("FAIL ev_pop: got %h required 01", d); end
      n_cmp++; if (events_o !== 1'b0) begin n_fail++; $display("FAIL ev_fall: got %b required 0", events_o); end
      apb_write(A_INT, 32'd0, e);
   endtask

   task automatic setup_midshift(input logic [6:0] rx_exp, input string nm);
      logic [31:0] d; logic e; int eb;
      apb_write(A_DIV, 32'd0, e);
      apb_write(A_LEN, 32'h0001_0007, e);
      apb_write(A_TX, 32'h5A, e);
      apb_write(A_CTRL, 32'h0000_0001, e);
      wait_idle(nm);
      apb_write(A_DIV, 32'd3, e);
      apb_write(A_LEN, 32'h0002_001F, e);
      apb_write(A_TX, 32'hDEAD_BEEF, e);
      apb_write(A_TX, 32'h0F0F_0F0F, e);
      eb = mon_edges;
      apb_write(A_CTRL, 32'h0000_0001, e);
      wait_edges(eb, 8, nm);
      apb_read(A_STAT, d, e);
      n_cmp++; if (d !== {9'd0, rx_exp, 1'b0, 7'd1, 7'd0, 1'b1}) begin n_fail++; $display("FAIL %s_pre: status %h required %h", nm, d, {9'd0, rx_exp, 1'b0, 7'd1, 7'd0, 1'b1}); end
   endtask

   task automatic test_swrst;
      logic [31:0] d; logic e;
      setup_midshift(7'd2, "swrst");
      apb_write(A_CTRL, 32'h0000_0010, e);
      n_cmp++; if (spi_csn !== 4'hF || spi_oe !== 1'b0 || spi_clk !== 1'b0) begin n_fail++; $display("FAIL swrst_pins: csn %h oe %b sck %b required f 0 0", spi_csn, spi_oe, spi_clk); end
      apb_read(A_STAT, d, e);
      n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL swrst_status: got %h required 0", d); end
      apb_read(A_DIV, d, e);
      n_cmp++; if (d !== 32'd3) begin n_fail++; $display("FAIL swrst_keep_cfg: div %h required 3", d); end
   endtask

   task automatic test_hreset_midshift;
      logic [31:0] d; logic e;
      setup_midshift(7'd1, "hrst");
      @(posedge HCLK); #1 HRESET = 1'b1;
      @(posedge HCLK); #1;
      n_cmp++; if (spi_csn !== 4'hF || spi_oe !== 1'b0 || spi_clk !== 1'b0) begin n_fail++; $display("FAIL hrst_pins: csn %h oe %b sck %b required f 0 0", spi_csn, spi_oe, spi_clk); end
      HRESET = 1'b0;
      apb_read(A_STAT, d, e);
      n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL hrst_status: got %h required 0", d); end
      apb_read(A_DIV, d, e);
      n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL hrst_div: got %h required 0", d); end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_cpol_cpha_lsb();
      test_stall();
      test_fifo_limits();
      test_events();
      test_swrst();
      test_hreset_midshift();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_spi_master_ncs.md
APB_SPI_MASTER_NCS -- requirements
Module: apb_spi_master_ncs

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning TX and RX FIFO depth in 32-bit words (power of two, 2..64).
REQ-002 SHALL have parameter NUM_CS, default 4, meaning the number of chip selects (1..8).
REQ-003 SHALL have parameter APB_ADDR_WIDTH, default 12, meaning the APB address width.
REQ-004 SHALL have ports:
- HCLK  in  1  clock; one clock, all logic on its rising edge.
- HRESET  in  1  synchronous active-high reset.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE, PSEL, PENABLE  in  1 each  APB control.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- events_o  out  1  interrupt.
- spi_clk  out  1  SCK.
- spi_csn  out  NUM_CS  active-low chip selects.
- spi_sdo  out  1  MOSI.
- spi_oe  out  1  MOSI output enable.
- spi_sdi  in  1  MISO.

Function
REQ-005 PREADY SHALL be tied 1 (zero-wait-state); a register access SHALL take effect in the PSEL&PENABLE cycle.
REQ-006 Register map (word offsets):
- 0x00 CTRL: [0] start (write-1 pulse, reads 0); [1] CPOL; [2] CPHA; [3] LSB-first; [4] swrst (write-1 pulse); [10:8] cs_idx.
- 0x04 CLKDIV: [15:0] div.
- 0x08 LEN: [5:0] frame_bits-1; [31:16] frame_cnt.
- 0x0C STATUS (RO): [0] busy; [14:8] tx_elems; [22:16] rx_elems.
- 0x10 TXDATA: write pushes TX FIFO.
- 0x14 RXDATA: read pops RX FIFO.
- 0x18 INT: [6:0] tx_th; [14:8] rx_th; [16] en_tx; [17] en_rx.
REQ-007 PSLVERR SHALL assert for an unmapped offset, a TXDATA write when TX is full (data dropped), an RXDATA read when RX is empty (PRDATA=0), any CTRL/CLKDIV/LEN write while busy (ignored), and cs_idx>=NUM_CS (ignored).
REQ-008 SCK half-period SHALL be div+1 HCLK cycles; div=0 gives SCK=HCLK/2.
REQ-009 FSM states SHALL be IDLE, CS_SETUP, LOAD, SHIFT, STORE, CS_HOLD.
- IDLE: start with frame_cnt!=0 -> CS_SETUP. start with frame_cnt=0 SHALL be ignored.
- CS_SETUP: assert spi_csn[cs_idx]=0 for one half-period -> LOAD.
- LOAD: wait for TX non-empty; pop one word into the shift register -> SHIFT.
- SHIFT: emit frame_bits bits.
- STORE: wait for RX not full; push the captured word, right-aligned and zero-extended; decrement the remaining count; if nonzero -> LOAD, else -> CS_HOLD.
- CS_HOLD: hold CS low for one half-period, then deassert -> IDLE.
REQ-010 SCK idle level SHALL be CPOL.
- CPHA=0: drive MOSI before the first edge; sample MISO on odd edges, shift on even edges.
- CPHA=1: shift on odd edges, sample on even edges.
- Each frame SHALL be exactly 2*frame_bits edges.
REQ-011 Bit order SHALL be MSB-first from bit frame_bits-1, or LSB-first from bit 0 when LSB-first=1.
REQ-012 SCK SHALL hold at CPOL while stalled in LOAD or STORE; CS SHALL stay asserted.
REQ-013 busy SHALL be 1 in every state except IDLE; spi_oe SHALL equal busy.
REQ-014 FIFOs SHALL be first-word-fall-through. Simultaneous push and pop SHALL both succeed, including when full (pop frees the slot) or empty (push only). The element count SHALL be exact 0..FIFO_DEPTH.
REQ-015 swrst SHALL clear both FIFOs and force the FSM to IDLE with CS deasserted and SCK=CPOL in the next cycle; configuration registers are retained.
REQ-016 events_o SHALL equal (en_tx & tx_elems<tx_th) | (en_rx & rx_elems>rx_th), combinationally from registered state.

Reset
REQ-017 On HRESET the following SHALL hold:
- All registers 0; FSM IDLE; FIFOs empty.
- spi_csn all 1; spi_clk 0; spi_sdo 0; spi_oe 0; events_o 0; PRDATA 0; PSLVERR 0.
REQ-018 HRESET SHALL override an in-progress transfer within one cycle.

Structure
REQ-019 A shared package apb_spi_ncs_pkg SHALL hold the register offset constants, the FSM state enum, and the CTRL field bit positions.
REQ-020 One sub-module, spi_ncs_fifo (parametrised DATA_WIDTH, DEPTH, with a clr input), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Mode 0 loopback (sdi=sdo), div=0, 8 bits, 1 frame, TX 0xA5: csn[0] low, 16 SCK edges, RX=0x000000A5, busy drops.
- CPOL=1, CPHA=1, LSB-first, 12 bits, cs_idx=2, TX 0x123: only csn[2] toggles; the sdo sequence is the LSB-first bits of 0x123; SCK idles high.
- frame_cnt=3 with one TX word preloaded: FSM stalls in LOAD, SCK static; writing 2 more words completes; RX holds 3 entries.
- Fill TX to FIFO_DEPTH, then one extra write: PSLVERR=1, tx_elems=FIFO_DEPTH; RXDATA read while empty: PSLVERR=1, PRDATA=0.
- rx_th=1, en_rx: events_o rises when the second word lands in RX and falls after one RXDATA pop.
- swrst mid-SHIFT (bit 4 of 32): next cycle csn all 1, busy=0, both element counts 0; HRESET in the same situation gives an identical result.
